register_shift_param: RTL
=========================

// Module: register_shift_param
// PURPOSE
//  Parametrised successor of the 4-bit datapath register: WIDTH-bit register loaded from the ULA
//  result, with logical/arithmetic shifts, rotates and clear. Adds multi-step shifting of up to
//  2**CNT_W-1 positions via a start/busy/done handshake to the control unit, serial-out, zero flag.
// PARAMETERS
//  WIDTH  8  data width (>=2)
//  CNT_W  4  width of shift-amount input; max multi-step count 2**CNT_W-1
// PORTS
//  clk     in   1        clock; all state updates on FALLING edge of clk
//  rst     in   1        synchronous, active-high reset, sampled on falling edge of clk
//  din     in   WIDTH    load data (ULA result)
//  op      in   3        operation code (below)
//  start   in   1        begin multi-step shift/rotate of `amount` steps
//  amount  in   CNT_W    step count, latched when start accepted
//  sin     in   1        serial fill bit (used only with SERIAL_IN_EN)
//  dout    out  WIDTH    register contents
//  sout    out  1        last bit shifted/rotated out
//  busy    out  1        multi-step operation in progress
//  done    out  1        one-cycle pulse: multi-step op finished
//  zero    out  1        combinational: dout == 0
// BEHAVIOUR
//  - op: 000 HOLD, 001 LOAD (dout<=din), 010 SHR, 011 SHL, 100 CLEAR (dout<=0, sout<=0),
//    101 ASR (MSB replicated), 110 ROR, 111 ROL. One step = shift/rotate by 1.
//  - rst=1: dout=0, sout=0, busy=0, done=0, state IDLE; overrides everything, incl. mid-RUN.
//  - FSM IDLE/RUN; counter cnt (CNT_W bits).
//  - IDLE, start=0: op executes once per falling edge (single-cycle, no done pulse).
//  - IDLE, start=1, op in {SHR,SHL,ASR,ROR,ROL}:
//    amount=0 -> no data change, done=1 next edge, stay IDLE;
//    amount=1 -> one step this edge, done=1 with it, stay IDLE;
//    amount>1 -> one step this edge, cnt<=amount-1, busy<=1, go RUN.
//  - IDLE, start=1 with HOLD/LOAD/CLEAR: start ignored, op executes as single-cycle.
//  - RUN: one step per edge with latched op; cnt decrements; on step where cnt==1: busy<=0,
//    done<=1, go IDLE. op/start/din/amount ignored while RUN (only rst acts).
//  - Latency: N-step op: busy high N-1 cycles, done asserted with final step (N edges after start).
//  - done: high exactly one cycle; cleared on every other edge.
//  - sout: updated with bit leaving dout on each step (LSB for SHR/ASR/ROR, MSB for SHL/ROL);
//    holds value on HOLD/LOAD; cleared by CLEAR and rst.
//  - amount > WIDTH legal: logical shifts reach 0, ASR reaches all-sign, rotates wrap modulo WIDTH.
//  - ROR/ROL: vacated bit = bit shifted out (sin never used). ASR fill = old MSB.
//  - start while busy: ignored, not queued.
// CONFIGURATION
//  SERIAL_IN_EN defined: SHR fills MSB with sin, SHL fills LSB with sin (sampled each step).
//  SERIAL_IN_EN undefined: SHR/SHL fill with 0; sin unused (port kept, ignored).
// TESTING
//  1. rst=1 with dout=8'hA5 mid-RUN -> next edge dout=0, busy=0, done=0, sout=0, zero=1.
//  2. LOAD 8'h96, op=SHR single-cycle -> dout=8'h4B, sout=0; op=SHL -> dout=8'h96, sout=0.
//  3. LOAD 8'h81, start=1 op=ROL amount=3 -> busy 2 cycles, done with dout=8'h0C, sout=0.
//  4. LOAD 8'h80, start=1 op=ASR amount=9 -> dout=8'hFF after 9 edges; op changed to CLEAR
//     during RUN ignored; done single pulse.
//  5. start=1 amount=0 op=SHR with dout=8'h3C -> dout unchanged, done=1 next edge, busy never 1.
//  6. SERIAL_IN_EN: LOAD 8'h00, sin=1, start op=SHR amount=4 -> dout=8'hF0; undefined -> 8'h00.

Source files
------------

// File: rtl/register_shift_param_if.sv
// Bus between the control unit (master) and the shift register (slave):
// load data, opcode, multi-step handshake and the register's observable state.
interface register_shift_param_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic [WIDTH-1:0] din;
  logic [2:0]       op;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic             sin;
  logic [WIDTH-1:0] dout;
  logic             sout;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output din, op, start, amount, sin,
    input  dout, sout, busy, done, zero
  );

  modport slave (
    input  din, op, start, amount, sin,
    output dout, sout, busy, done, zero
  );
endinterface

// File: rtl/register_shift_param.sv
// WIDTH-bit datapath register with shifts/rotates/clear and multi-step start/busy/done handshake.
// Define SERIAL_IN_EN to fill SHR/SHL vacated bits from sin instead of zero. State moves on falling clk.
module register_shift_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  register_shift_param_if.slave bus
);
  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHR   = 3'b010;
  localparam logic [2:0] OP_SHL   = 3'b011;
  localparam logic [2:0] OP_CLEAR = 3'b100;
  localparam logic [2:0] OP_ASR   = 3'b101;
  localparam logic [2:0] OP_ROR   = 3'b110;
  localparam logic [2:0] OP_ROL   = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_run_q, op_run_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_data;
  logic             step_out;
  logic             fill;
  logic             start_step;

`ifdef SERIAL_IN_EN
  assign fill = bus.sin;
`else
  logic unused_sin;
  assign fill       = 1'b0;
  assign unused_sin = bus.sin;
`endif

  function automatic logic is_step_op(input logic [2:0] op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ASR) ||
           (op == OP_ROR) || (op == OP_ROL);
  endfunction

  assign start_step = (state_q == IDLE) && bus.start && is_step_op(bus.op);

  // One-position step unit; in RUN it follows the op latched at start, not the live opcode.
  always_comb begin
    step_op   = (state_q == RUN) ? op_run_q : bus.op;
    step_data = dout_q;
    step_out  = sout_q;
    case (step_op)
      OP_SHR: begin
        step_data = {fill, dout_q[WIDTH-1:1]};
        step_out  = dout_q[0];
      end
      OP_SHL: begin
        step_data = {dout_q[WIDTH-2:0], fill};
        step_out  = dout_q[WIDTH-1];
      end
      OP_ASR: begin
        step_data = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
        step_out  = dout_q[0];
      end
      OP_ROR: begin
        step_data = {dout_q[0], dout_q[WIDTH-1:1]};
        step_out  = dout_q[0];
      end
      OP_ROL: begin
        step_data = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
        step_out  = dout_q[WIDTH-1];
      end
      default: begin
        step_data = dout_q;
        step_out  = sout_q;
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_run_q <= OP_HOLD;
      dout_q   <= '0;
      sout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_run_q <= op_run_d;
      dout_q   <= dout_d;
      sout_q   <= sout_d;
      done_q   <= done_d;
    end
  end

  // The start edge already performs the first step, so RUN only covers the remaining amount-1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_run_d = op_run_q;
    case (state_q)
      IDLE: begin
        if (start_step && (bus.amount > CNT_ONE)) begin
          state_d  = RUN;
          cnt_d    = bus.amount - CNT_ONE;
          op_run_d = bus.op;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    sout_d = sout_q;
    done_d = 1'b0;
    if (state_q == RUN) begin
      dout_d = step_data;
      sout_d = step_out;
      done_d = (cnt_q == CNT_ONE);
    end else if (start_step) begin
      if (bus.amount != CNT_ZERO) begin
        dout_d = step_data;
        sout_d = step_out;
      end
      done_d = (bus.amount <= CNT_ONE);
    end else begin
      case (bus.op)
        OP_LOAD:  dout_d = bus.din;
        OP_CLEAR: begin
          dout_d = '0;
          sout_d = 1'b0;
        end
        default: begin
          dout_d = step_data;
          sout_d = step_out;
        end
      endcase
    end
  end

  always_comb begin
    bus.dout = dout_q;
    bus.sout = sout_q;
    bus.done = done_q;
    bus.busy = (state_q == RUN);
    bus.zero = (dout_q == '0);
  end
endmodule
